// File: rtl/pipe_stage_latch_pkg.sv
// Shared pipeline constants: default NOP encoding and common word/counter widths.
package pipe_pkg;

   localparam int unsigned PIPE_WORD_W = 32;
   localparam int unsigned STALL_CNT_W = 16;
   localparam logic [PIPE_WORD_W-1:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_latch_reg.sv
// pipe_reg: enabled register with synchronous clear and asynchronous reset, both to RESET_VAL.
module pipe_reg #(
   parameter int unsigned WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // clear outranks enable so a flush wins over a stall
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q <= RESET_VAL;
      end else if (clear) begin
         r_q <= RESET_VAL;
      end else if (enable) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline stage latch with stall/flush; field 0 is the instruction word.
// Optional stall counter enabled by defining PIPE_STAGE_LATCH_STALL_CNT_EN.
module pipe_stage_latch
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NFIELDS = 4,
   parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_INSN)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       flush,
   input  logic                       valid_in,
   input  logic [NFIELDS*WIDTH-1:0]   fields_in,
   output logic                       valid_out,
   output logic [NFIELDS*WIDTH-1:0]   fields_out,
   output logic [STALL_CNT_W-1:0]     stall_cycles
);

   logic [NFIELDS*WIDTH-1:0] w_fields_d;

   // An invalid incoming word always presents a NOP in the instruction field
   always_comb begin
      w_fields_d = fields_in;
      if (!valid_in) begin
         w_fields_d[0 +: WIDTH] = NOP_WORD;
      end
   end

   for (genvar k = 0; k < NFIELDS; k++) begin : g_field
      pipe_reg #(
         .WIDTH     (WIDTH),
         .RESET_VAL ((k == 0) ? NOP_WORD : '0)
      ) u_field (
         .clock  (clock),
         .reset  (reset),
         .enable (enable),
         .clear  (flush),
         .d      (w_fields_d[k*WIDTH +: WIDTH]),
         .q      (fields_out[k*WIDTH +: WIDTH])
      );
   end

   pipe_reg #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) u_valid (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .clear  (flush),
      .d      (valid_in),
      .q      (valid_out)
   );

`ifdef PIPE_STAGE_LATCH_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] r_stall_cnt;
   logic                   w_stall;

   // Flush takes precedence, so a flushed edge is never counted as a stall
   assign w_stall = !enable && !flush && valid_out;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cycles = r_stall_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipe_stage_latch.md
PIPE_STAGE_LATCH -- requirements
Module: pipe_stage_latch

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each field.
REQ-002 SHALL have parameter NFIELDS, default 4: number of fields; field 0 is the instruction (IR) field.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000000: value loaded into field 0 on reset or flush.
REQ-004 SHALL have port clock, input, 1: single rising-edge clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: 1 = load stage, 0 = stall (hold).
REQ-007 SHALL have port flush, input, 1: replace stage contents with a bubble.
REQ-008 SHALL have port valid_in, input, 1: incoming word is a real instruction.
REQ-009 SHALL have port fields_in, input, NFIELDS*WIDTH: packed fields, field k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port valid_out, output, 1: stage holds a real instruction.
REQ-011 SHALL have port fields_out, output, NFIELDS*WIDTH: registered fields, same packing.
REQ-012 SHALL have port stall_cycles, output, 16: count of stalled valid cycles.

Function
REQ-013 SHALL update only on the rising edge of clock, except for reset.
REQ-014 SHALL apply priority reset > flush > enable > hold.
REQ-015 SHALL, when flush=1 at an edge, load field 0 = NOP_WORD, fields 1..NFIELDS-1 = 0, valid_out = 0, regardless of enable.
REQ-016 SHALL, when flush=0 and enable=1, load fields_out = fields_in and valid_out = valid_in, with one-cycle latency.
REQ-017 SHALL, when flush=0 and enable=0, hold fields_out and valid_out unchanged.
REQ-018 SHALL, when valid_in=0 and enable=1, load field 0 = NOP_WORD and the other fields from fields_in, so an invalid word always presents a NOP.
REQ-019 SHALL have no combinational path from any input to any output.
REQ-020 SHALL have stall_cycles increment by 1 on each edge where enable=0, flush=0, and valid_out=1.
REQ-021 SHALL have stall_cycles saturate at 16'hFFFF, with no wrap.
REQ-022 SHALL leave stall_cycles unchanged by flush.
REQ-023 SHALL have stall_cycles count a simultaneous enable=0 and flush=1 as a flush, not a stall.

Reset
REQ-024 SHALL, on reset asserted at any time, immediately drive field 0 = NOP_WORD, fields 1..NFIELDS-1 = 0, valid_out = 0, and stall_cycles = 0.
REQ-025 SHALL hold the reset values while reset=1, ignoring enable and flush.
REQ-026 SHALL, after reset deasserts, take the first load at the next rising edge per REQ-014.

Configuration
REQ-027 SHALL, with macro PIPE_STAGE_LATCH_STALL_CNT_EN defined, implement the stall counter per REQ-020..REQ-023.
REQ-028 SHALL, without PIPE_STAGE_LATCH_STALL_CNT_EN, keep port stall_cycles present, tie it to 16'h0000, and instantiate no counter flops.

Structure
REQ-029 SHALL place in shared package pipe_pkg: constant NOP_INSN (default for NOP_WORD), constant PIPE_WORD_W = 32, constant STALL_CNT_W = 16.
REQ-030 SHALL use one sub-module, pipe_reg (parameters WIDTH, RESET_VAL; ports clock, reset, enable, clear, d, q), instantiated once per field plus once for valid.
REQ-031 SHALL give pipe_reg this behaviour: clear loads RESET_VAL synchronously, and reset loads it asynchronously.

Verification
REQ-032 SHALL cover: default params, enable=1, valid_in=1, fields_in={32'hD,32'hC,32'hB,32'hA} -> after 1 edge, fields_out equal input and valid_out=1.
REQ-033 SHALL cover: loaded stage, enable=0 for 5 edges while fields_in changes -> fields_out unchanged, and stall_cycles=5 (0 without the macro).
REQ-034 SHALL cover: enable=0 and flush=1 at the same edge -> field 0 = NOP_WORD, other fields 0, valid_out=0, stall_cycles unchanged.
REQ-035 SHALL cover: valid_in=0, enable=1, field 0 input = 32'hFFFFFFFF -> field 0 out = NOP_WORD and valid_out=0.
REQ-036 SHALL cover: reset pulsed between clock edges while loaded -> outputs reach reset values before the next edge, and the first post-reset load follows REQ-014.
REQ-037 SHALL cover: stall counter preset near the limit via 65540 stalled cycles -> stall_cycles = 16'hFFFF, with no wrap.
